relu_pool2x2: RTL and testbench
===============================

# relu_pool2x2

Streaming ReLU plus 2×2 max-pool stage that sits directly downstream of the 16-output convolution accumulator. It consumes one multi-channel conv pixel per `in_en` beat, in row-major order, and clamps negatives to zero. It emits one pooled pixel per 2×2 window. A single half-row line buffer holds the partial maxima, so no full-frame storage is needed.

## Interface
Parameters:
- `CH`, 16, channels per pixel; matches the conv stage `OUTPUT_NUM`.
- `IMG_W`, 8, input frame width in pixels; must be even.
- `IMG_H`, 8, input frame height in pixels; must be even.

Ports (`` `WD `` from `global.v`):
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_clr`  in  1  synchronous frame restart; clears the counters and the line-buffer valid state.
- `in_en`  in  1  input pixel valid; driven from conv `q_en`.
- `in_data`  in  `` `WD*CH ``  CH signed channels; channel i is at `[`WD*(CH-i)-1 -: `WD]`, with ch0 in the MSBs, matching conv `q`.
- `out_en`  out  1  pooled pixel valid, one-cycle pulse.
- `out_data`  out  `` `WD*CH ``  pooled channels, same packing; always ≥ 0.
- `frame_done`  out  1  pulses together with the last `out_en` of a frame.

## Operation
- Counters:
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1.
  - Both advance only on accepted `in_en`.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_W-1, IMG_H-1) both wrap to 0, and the next beat is pixel (0,0) of a new frame.
- ReLU, per channel: `r = x[WD-1] ? 0 : x`. After ReLU all comparisons are unsigned.
- Horizontal stage:
  - Even `col`: `hreg <= r`.
  - Odd `col`: `h = max(hreg, r)` per channel, combinational.
- Vertical stage, using line buffer `lb[0..IMG_W/2-1]` of `` `WD*CH `` bits each:
  - Even `row`, odd `col`: `lb[col>>1] <= h`.
  - Odd `row`, odd `col`: `out_data <= max(lb[col>>1], h)` per channel, and `out_en <= 1`.
- `frame_done <= 1` in the same cycle `out_en` is set for input pixel (IMG_W-1, IMG_H-1).
- Gaps in `in_en` are allowed anywhere, and all state holds across them.
- `in_clr`:
  - Zeroes `col`, `row` and `hreg`.
  - Does not need to clear `lb`, because `lb` is always rewritten before it is read.
  - If `in_clr` and `in_en` are high in the same cycle, `in_clr` wins and the pixel is dropped.
- `in_clr` does not suppress an `out_en` already registered in the previous cycle.

## Timing
- Reset values: `out_en` = 0, `out_data` = 0, `frame_done` = 0, `col` = 0, `row` = 0, `hreg` = 0.
- Latency: `out_en` asserts exactly 1 cycle after the `in_en` beat carrying pixel (odd col, odd row).
- `out_data` holds its value until the next `out_en`. `out_en` and `frame_done` are single-cycle pulses.
- Throughput: one input per cycle sustained; output rate is 1/4 of input rate. Back-to-back outputs never occur; with no input gaps the minimum spacing is 2 cycles.
- Reset mid-frame: all state clears asynchronously, and the first `in_en` after release is pixel (0,0).
- Output count per frame: (IMG_W/2)·(IMG_H/2), which is 16 at the defaults.
- The conv stage output is already truncated to `` `WD ``. No additional scaling is applied here.

## Test plan
- **Ramp frame.** Channel c of pixel (x,y) = y·8+x+c; 64 beats with `in_en` high every cycle.
  - Expect 16 `out_en` pulses. Pooled (i,j) on ch0 = (2j+1)·8+2i+1; the first output is 9, the last is 63.
  - `frame_done` fires only with the 16th pulse, 1 cycle after the 64th beat.
- **Negatives.** Every pixel is -5 except pixel (1,1), which is +3.
  - First output = 3 on all channels.
  - All other outputs = 0, confirming ReLU is applied before the max.
- **Max position.** Drive a single maximum of 100 in each of the four positions of window (0,0) in turn, on ch15 only.
  - Output ch15 = 100 each time, with the other channels 0.
  - This confirms the channel packing.
- **Gapped input.** Same stimulus as the ramp frame, with `in_en` high on only 1 of every 3 cycles.
  - Identical output values.
  - Each `out_en` arrives exactly 1 cycle after its triggering beat.
- **Restart.**
  - Assert `in_clr` after 20 beats, together with an `in_en` beat; that pixel is dropped.
  - Then send a full ramp frame: expect the same 16 outputs as the ramp-frame case.
  - Repeat with `rst_n` pulsed low mid-frame: all outputs read 0 during reset, and the next frame pools correctly.
- **Back-to-back frames.** Send two ramp frames with no gap between them.
  - Expect 32 outputs and 2 `frame_done` pulses.
  - Frame 2 values equal frame 1 values, with no carry-over in `lb` or `hreg`.

Source files
------------

// File: rtl/relu_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module      : relu_pool2x2
//  Description : Streaming ReLU followed by 2x2 max-pool over a row-major
//                multi-channel pixel stream. Negative channels are clamped
//                to zero, horizontal pairs are reduced through a one-pixel
//                holding register, and vertical pairs through a half-row
//                line buffer. One pooled pixel is emitted per 2x2 window.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CH     channels per pixel
//    IMG_W  input frame width in pixels (even)
//    IMG_H  input frame height in pixels (even)
//    WD     bits per channel (signed on input)
//  Ports
//    clk         rising-edge clock
//    rst_n       asynchronous active-low reset
//    in_clr      synchronous frame restart (wins over in_en)
//    in_en       input pixel valid
//    in_data     CH signed channels, ch0 in the MSBs
//    out_en      pooled pixel valid, single-cycle pulse
//    out_data    pooled channels, same packing, always >= 0
//    frame_done  pulses with the last out_en of a frame
// ============================================================================
module relu_pool2x2 #(
  parameter int CH    = 16,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WD    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_clr,
  input  logic             in_en,
  input  logic [WD*CH-1:0] in_data,
  output logic             out_en,
  output logic [WD*CH-1:0] out_data,
  output logic             frame_done
);

  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LBN = IMG_W / 2;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WD*CH-1:0] hreg_q, hreg_d;
  logic [WD*CH-1:0] lb_q [LBN];
  logic [WD*CH-1:0] lb_d [LBN];
  logic             out_en_q, out_en_d;
  logic [WD*CH-1:0] out_data_q, out_data_d;
  logic             frame_done_q, frame_done_d;

  // --------------------------------------------------------------------------
  // Per-channel datapath
  // --------------------------------------------------------------------------
  logic [WD*CH-1:0] relu_data;   // clamped input pixel
  logic [WD*CH-1:0] hmax_data;   // max of held even-column pixel and current
  logic [WD*CH-1:0] vmax_data;   // max of line-buffer entry and hmax_data
  logic [WD*CH-1:0] lb_rd;
  logic [LBW-1:0]   lb_idx;
  logic             last_col;
  logic             last_row;

  // Each horizontal pair maps to one line-buffer slot.
  assign lb_idx   = LBW'(col_q >> 1);
  assign lb_rd    = lb_q[lb_idx];
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      localparam int HI = WD * (CH - c) - 1;
      logic [WD-1:0] x_raw;
      logic [WD-1:0] x_relu;
      logic [WD-1:0] h_held;
      logic [WD-1:0] h_max;
      logic [WD-1:0] v_held;

      assign x_raw  = in_data[HI -: WD];
      // After clamping every value is non-negative, so the maxima below
      // are plain unsigned comparisons.
      assign x_relu = x_raw[WD-1] ? '0 : x_raw;
      assign h_held = hreg_q[HI -: WD];
      assign h_max  = (h_held > x_relu) ? h_held : x_relu;
      assign v_held = lb_rd[HI -: WD];

      assign relu_data[HI -: WD] = x_relu;
      assign hmax_data[HI -: WD] = h_max;
      assign vmax_data[HI -: WD] = (v_held > h_max) ? v_held : h_max;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hreg_d       = hreg_q;
    lb_d         = lb_q;
    out_en_d     = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;

    if (in_clr) begin
      // The line buffer is left alone: every slot is written on an even
      // row before the odd row reads it.
      col_d  = '0;
      row_d  = '0;
      hreg_d = '0;
    end else if (in_en) begin
      if (!col_q[0]) begin
        hreg_d = relu_data;
      end else if (!row_q[0]) begin
        lb_d[lb_idx] = hmax_data;
      end else begin
        out_data_d   = vmax_data;
        out_en_d     = 1'b1;
        frame_done_d = last_col && last_row;
      end

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hreg_q       <= '0;
      out_en_q     <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < LBN; i++) begin
        lb_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hreg_q       <= hreg_d;
      out_en_q     <= out_en_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < LBN; i++) begin
        lb_q[i] <= lb_d[i];
      end
    end
  end

  assign out_en     = out_en_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_pool2x2
//  Description : Self-checking bench for relu_pool2x2. Each frame is held as
//                a 2-D pixel array; expected pooled values are the max of
//                the clamped 2x2 window taken straight from that array.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_relu_pool2x2;

  localparam int CH = 16;
  localparam int WD = 16;
  localparam int W  = 8;
  localparam int H  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_clr;
  logic             in_en;
  logic [WD*CH-1:0] in_data;
  logic             out_en;
  logic [WD*CH-1:0] out_data;
  logic             frame_done;

  always #5 clk = ~clk;

  relu_pool2x2 #(.CH(CH), .IMG_W(W), .IMG_H(H), .WD(WD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_clr     (in_clr),
    .in_en      (in_en),
    .in_data    (in_data),
    .out_en     (out_en),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_done = 0;

  logic [WD-1:0]    pix [H][W][CH];
  logic [WD*CH-1:0] last_exp;
  logic [WD*CH-1:0] first_dut;
  logic [WD*CH-1:0] final_dut;

  task automatic chk(input string tag, input logic [WD*CH-1:0] obs,
                     input logic [WD*CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD-1:0] relu(input logic [WD-1:0] v);
    return v[WD-1] ? '0 : v;
  endfunction

  function automatic logic [WD*CH-1:0] pack_pixel(input int x, input int y);
    logic [WD*CH-1:0] p;
    p = '0;
    for (int c = 0; c < CH; c++) p[WD*(CH-c)-1 -: WD] = pix[y][x][c];
    return p;
  endfunction

  // Reference pooled pixel (i,j): max over the clamped 2x2 window.
  function automatic logic [WD*CH-1:0] pool(input int i, input int j);
    logic [WD*CH-1:0] p;
    logic [WD-1:0]    m;
    logic [WD-1:0]    r;
    p = '0;
    for (int c = 0; c < CH; c++) begin
      m = '0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          r = relu(pix[2*j+dy][2*i+dx][c]);
          if (r > m) m = r;
        end
      p[WD*(CH-c)-1 -: WD] = m;
    end
    return p;
  endfunction

  task automatic fill_ramp();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CH; c++) pix[y][x][c] = WD'(y*8 + x + c);
  endtask

  task automatic fill_const(input logic [WD-1:0] v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CH; c++) pix[y][x][c] = v;
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CH; c++) pix[y][x][c] = WD'($urandom());
  endtask

  // Idle cycles: nothing may come out and out_data must hold.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_en   = 1'b0;
      in_data = {8{$urandom()}};
      @(posedge clk); #1;
      chk("idle_out_en", WD*CH'(out_en), '0);
      chk("idle_frame_done", WD*CH'(frame_done), '0);
      chk("idle_hold", out_data, last_exp);
    end
  endtask

  // One accepted beat carrying pixel (x,y); checked one cycle later.
  task automatic beat(input int x, input int y);
    logic is_out;
    logic is_last;
    in_en   = 1'b1;
    in_data = pack_pixel(x, y);
    @(posedge clk); #1;
    in_en   = 1'b0;
    is_out  = (x % 2 == 1) && (y % 2 == 1);
    is_last = is_out && (x == W-1) && (y == H-1);
    if (is_out) last_exp = pool(x/2, y/2);
    chk($sformatf("out_en(%0d,%0d)", x, y), WD*CH'(out_en), WD*CH'(is_out));
    chk($sformatf("frame_done(%0d,%0d)", x, y), WD*CH'(frame_done), WD*CH'(is_last));
    chk($sformatf("out_data(%0d,%0d)", x, y), out_data, last_exp);
    if (out_en) n_out++;
    if (frame_done) n_done++;
    if (x == 1 && y == 1) first_dut = out_data;
    if (x == W-1 && y == H-1) final_dut = out_data;
  endtask

  // gap < 0 selects a random 0..2 idle cycles after each beat.
  task automatic send_frame(input int gap);
    int o0;
    o0 = n_out;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        beat(x, y);
        if (gap > 0) idle(gap);
        else if (gap < 0) idle(int'($urandom_range(0, 2)));
      end
    chk("frame_out_count", WD*CH'(n_out - o0), WD*CH'((W/2)*(H/2)));
  endtask

  initial begin
    int d0;
    int o0;
    rst_n    = 1'b0;
    in_clr   = 1'b0;
    in_en    = 1'b0;
    in_data  = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_en", WD*CH'(out_en), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_frame_done", WD*CH'(frame_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, continuous input.
    fill_ramp();
    d0 = n_done;
    send_frame(0);
    chk("ramp_first_ch0", WD*CH'(first_dut[WD*CH-1 -: WD]), WD*CH'(9));
    chk("ramp_last_ch0", WD*CH'(final_dut[WD*CH-1 -: WD]), WD*CH'(63));
    chk("ramp_done_count", WD*CH'(n_done - d0), WD*CH'(1));
    idle(2);

    // Negatives with one positive pixel at (1,1).
    fill_const(WD'(-5));
    for (int c = 0; c < CH; c++) pix[1][1][c] = WD'(3);
    send_frame(0);
    chk("neg_first", first_dut, {CH{WD'(3)}});
    idle(1);

    // A single maximum on ch15 in each position of window (0,0).
    for (int p = 0; p < 4; p++) begin
      fill_const('0);
      pix[p/2][p%2][CH-1] = WD'(100);
      send_frame(0);
      chk($sformatf("maxpos%0d", p), first_dut, (WD*CH)'(100));
    end

    // Gapped ramp: one beat every third cycle.
    fill_ramp();
    send_frame(2);
    chk("gap_first_ch0", WD*CH'(first_dut[WD*CH-1 -: WD]), WD*CH'(9));

    // Restart with in_clr after 20 beats, colliding with an in_en beat.
    fill_ramp();
    for (int k = 0; k < 20; k++) beat(k % W, k / W);
    in_clr  = 1'b1;
    in_en   = 1'b1;
    in_data = pack_pixel(4, 2);
    @(posedge clk); #1;
    in_clr  = 1'b0;
    in_en   = 1'b0;
    chk("clr_out_en", WD*CH'(out_en), '0);
    send_frame(0);
    idle(1);

    // Asynchronous reset mid-frame, just after an output was produced.
    fill_random();
    for (int k = 0; k < 12; k++) beat(k % W, k / W);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_en", WD*CH'(out_en), '0);
    chk("rst_mid_out_data", out_data, '0);
    chk("rst_mid_frame_done", WD*CH'(frame_done), '0);
    @(posedge clk); #1;
    chk("rst_hold_out_data", out_data, '0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = '0;
    @(posedge clk); #1;
    fill_ramp();
    send_frame(0);

    // Back-to-back ramp frames.
    d0 = n_done;
    o0 = n_out;
    send_frame(0);
    send_frame(0);
    chk("b2b_outs", WD*CH'(n_out - o0), WD*CH'(32));
    chk("b2b_done", WD*CH'(n_done - d0), WD*CH'(2));

    // Random frames with random gaps.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(-1);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
